// File: rtl/hs_mem_param_if.sv
// hs_mem_param_if: request/response bundle for the hs_mem_param handshake memory.
//   read, write  : level requests, held by the master until ack
//   addr         : word address (ADDR_W bits)
//   data_i, be   : write data and per-byte write enables
//   data_o       : read data, valid only while ack is high
//   ack, err     : single-cycle completion strobe and its out-of-range qualifier
//   busy         : a transaction is pending inside the slave
// DATA_W and ADDR_W must match the parameters of the attached hs_mem_param.
interface hs_mem_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_i;
  logic [DATA_W/8-1:0]   be;
  logic [DATA_W-1:0]     data_o;
  logic                  ack;
  logic                  err;
  logic                  busy;

  modport master (
    output read, write, addr, data_i, be,
    input  data_o, ack, err, busy
  );

  modport slave (
    input  read, write, addr, data_i, be,
    output data_o, ack, err, busy
  );
endinterface

// File: rtl/hs_mem_param.sv
// hs_mem_param: single-port handshake memory with a fixed response latency,
// byte-enabled writes, out-of-range error response and a busy indication.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (control and response registers only;
//           the memory array itself is never reset)
//   bus   : hs_mem_param_if slave modport (read/write/addr/data_i/be in,
//           data_o/ack/err/busy out)
// Optional build macro HS_MEM_RAND_LAT_EN: when defined, each accepted request
// waits a random LAT..LAT_MAX cycles (simulation only). Undefined, the wait is
// exactly LAT cycles and the block is fully synthesizable.
module hs_mem_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int LAT     = 3,
  parameter int LAT_MAX = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  hs_mem_param_if.slave   bus
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter is sized for the largest latency the block can ever load.
  localparam int CNT_W = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                op_q, op_d;        // 0 = read, 1 = write
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NB-1:0]       be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                mem_we;
  logic                abort;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    lat_load;

  logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef HS_MEM_RAND_LAT_EN
  // A fresh draw every cycle; whichever value is present at acceptance is used.
  logic [CNT_W-1:0] lat_rand_q;
  always_ff @(posedge clk) begin
    lat_rand_q <= CNT_W'($urandom_range(LAT_MAX, LAT));
  end
  assign lat_load = lat_rand_q;
`else
  assign lat_load = CNT_W'(LAT);
`endif

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  // Truncation is safe: the index is only used when the address is in range.
  assign idx      = addr_q[IDX_W-1:0];

  // A held request that differs from what was latched cancels the transaction.
  assign abort = op_q ? (!bus.write || (bus.addr != addr_q) ||
                         (bus.data_i != data_q) || (bus.be != be_q))
                      : (!bus.read || (bus.addr != addr_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous read and write is not a valid request and is ignored.
        if (bus.read ^ bus.write) begin
          op_d    = bus.write;
          addr_d  = bus.addr;
          data_d  = bus.data_i;
          be_d    = bus.be;
          cnt_d   = lat_load;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = RESP;
          if (!in_range) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else if (op_q) begin
            mem_we  = 1'b1;
          end else begin
            rdata_d = mem_q[idx];
          end
        end
      end
      RESP: begin
        // Clearing here keeps data_o/err at zero everywhere outside RESP.
        state_d = IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (be_q[i]) mem_q[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

  assign bus.ack    = (state_q == RESP);
  assign bus.busy   = (state_q != IDLE);
  assign bus.err    = err_q;
  assign bus.data_o = rdata_q;
endmodule

// File: tb/tb_hs_mem_param.sv
// tb_hs_mem_param: directed bench for hs_mem_param.
// u0: default build (8-bit, DEPTH=32, LAT=3); u1: 16-bit, DEPTH=20, LAT=1.
module tb_hs_mem_param;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  hs_mem_param_if #(.DATA_W(8),  .ADDR_W(5)) if0 ();
  hs_mem_param_if #(.DATA_W(16), .ADDR_W(5)) if1 ();

  hs_mem_param #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .LAT(3), .LAT_MAX(10)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  hs_mem_param #(.DATA_W(16), .ADDR_W(5), .DEPTH(20), .LAT(1), .LAT_MAX(10)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction on u0; lat = edges after acceptance until ack (-1 on timeout).
  task automatic drv0(input logic wr, input logic [4:0] a, input logic [7:0] d,
                      input logic b, output int lat, output logic [7:0] dout,
                      output logic e, output logic busy1, output logic ack_nx,
                      output logic [7:0] dout_nx);
    if0.read = !wr; if0.write = wr; if0.addr = a; if0.data_i = d; if0.be = b;
    tick;
    busy1 = if0.busy;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (if0.ack) begin lat = i; break; end
      tick;
    end
    dout = if0.data_o; e = if0.err;
    if0.read = 1'b0; if0.write = 1'b0;
    tick;
    ack_nx = if0.ack; dout_nx = if0.data_o;
  endtask

  task automatic drv1(input logic wr, input logic [4:0] a, input logic [15:0] d,
                      input logic [1:0] b, output int lat, output logic [15:0] dout,
                      output logic e, output logic busy1, output logic ack_nx,
                      output logic [15:0] dout_nx);
    if1.read = !wr; if1.write = wr; if1.addr = a; if1.data_i = d; if1.be = b;
    tick;
    busy1 = if1.busy;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (if1.ack) begin lat = i; break; end
      tick;
    end
    dout = if1.data_o; e = if1.err;
    if1.read = 1'b0; if1.write = 1'b0;
    tick;
    ack_nx = if1.ack; dout_nx = if1.data_o;
  endtask

  task automatic test_reset;
    int seen;
    rst_n = 1'b0;
    if0.read = 1'b1; if0.addr = 5'd0;
    tick; tick; tick;
    n_cmp++; if (if0.ack !== 1'b0) begin n_err++; $display("FAIL rst_ack got=%b exp=0", if0.ack); end
    n_cmp++; if (if0.err !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b exp=0", if0.err); end
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", if0.busy); end
    n_cmp++; if (if0.data_o !== 8'h00) begin n_err++; $display("FAIL rst_data got=%h exp=00", if0.data_o); end
    n_cmp++; if (if1.busy !== 1'b0 || if1.data_o !== 16'h0) begin n_err++;
      $display("FAIL rst_u1 busy=%b data=%h exp busy=0 data=0000", if1.busy, if1.data_o); end
    rst_n = 1'b1;
    tick;
    n_cmp++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL rst_first_accept got=%b exp=1", if0.busy); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (if0.ack) begin seen = 1; break; end
      tick;
    end
    if0.read = 1'b0;
    n_cmp++; if (seen !== 1) begin n_err++; $display("FAIL rst_first_ack got=%0d exp=1", seen); end
    tick;
  endtask

  task automatic test_basic;
    int lat; logic [7:0] d, dn; logic e, b1, an;
    drv0(1'b1, 5'd5, 8'hA5, 1'b1, lat, d, e, b1, an, dn);
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL wr_busy got=%b exp=1", b1); end
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wr_latency got=%0d exp=4", lat); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL wr_err got=%b exp=0", e); end
    n_cmp++; if (an !== 1'b0) begin n_err++; $display("FAIL wr_ack_single got=%b exp=0", an); end
    drv0(1'b0, 5'd5, 8'h00, 1'b0, lat, d, e, b1, an, dn);
    n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL rd_latency got=%0d exp=4", lat); end
    n_cmp++; if (d !== 8'hA5) begin n_err++; $display("FAIL rd_data got=%h exp=a5", d); end
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL rd_err got=%b exp=0", e); end
    n_cmp++; if (an !== 1'b0 || dn !== 8'h00) begin n_err++;
      $display("FAIL rd_after_resp ack=%b data=%h exp ack=0 data=00", an, dn); end
  endtask

  task automatic test_byte_en;
    int lat; logic [15:0] d, dn; logic e, b1, an;
    drv1(1'b1, 5'd2, 16'h1234, 2'b11, lat, d, e, b1, an, dn);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL be_latency got=%0d exp=2", lat); end
    drv1(1'b1, 5'd2, 16'hABCD, 2'b10, lat, d, e, b1, an, dn);
    drv1(1'b0, 5'd2, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (d !== 16'hAB34) begin n_err++; $display("FAIL be_merge got=%h exp=ab34", d); end
    drv1(1'b1, 5'd2, 16'hFFFF, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (lat !== 2 || e !== 1'b0) begin n_err++;
      $display("FAIL be_zero_ack lat=%0d err=%b exp lat=2 err=0", lat, e); end
    drv1(1'b0, 5'd2, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (d !== 16'hAB34) begin n_err++; $display("FAIL be_zero_keep got=%h exp=ab34", d); end
  endtask

  task automatic test_abort;
    int lat, acks; logic [7:0] d, dn; logic e, b1, an;
    drv0(1'b1, 5'd3, 8'h00, 1'b1, lat, d, e, b1, an, dn);
    if0.write = 1'b1; if0.addr = 5'd3; if0.data_i = 8'h11; if0.be = 1'b1;
    tick;
    n_cmp++; if (if0.busy !== 1'b1) begin n_err++; $display("FAIL abort_accept got=%b exp=1", if0.busy); end
    if0.data_i = 8'h22;
    tick;
    n_cmp++; if (if0.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", if0.busy); end
    if0.write = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (if0.ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    drv0(1'b0, 5'd3, 8'h00, 1'b0, lat, d, e, b1, an, dn);
    n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL abort_mem got=%h exp=00", d); end
    // Read aborted by an address change.
    if1.read = 1'b1; if1.addr = 5'd2;
    tick;
    if1.addr = 5'd3;
    tick;
    n_cmp++; if (if1.busy !== 1'b0 || if1.ack !== 1'b0) begin n_err++;
      $display("FAIL abort_rd busy=%b ack=%b exp 0 0", if1.busy, if1.ack); end
    if1.read = 1'b0;
    tick;
  endtask

  task automatic test_err;
    int lat; logic [15:0] d, dn; logic e, b1, an;
    drv1(1'b0, 5'd25, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (lat !== 2 || e !== 1'b1 || d !== 16'h0) begin n_err++;
      $display("FAIL err_rd lat=%0d err=%b data=%h exp 2 1 0000", lat, e, d); end
    n_cmp++; if (an !== 1'b0 || dn !== 16'h0) begin n_err++;
      $display("FAIL err_clear ack=%b data=%h exp 0 0000", an, dn); end
    drv1(1'b1, 5'd25, 16'h5555, 2'b11, lat, d, e, b1, an, dn);
    n_cmp++; if (lat !== 2 || e !== 1'b1) begin n_err++;
      $display("FAIL err_wr lat=%0d err=%b exp 2 1", lat, e); end
    drv1(1'b0, 5'd25, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (e !== 1'b1 || d !== 16'h0) begin n_err++;
      $display("FAIL err_rd2 err=%b data=%h exp 1 0000", e, d); end
    drv1(1'b1, 5'd19, 16'h5A5A, 2'b11, lat, d, e, b1, an, dn);
    n_cmp++; if (e !== 1'b0) begin n_err++; $display("FAIL edge_wr19 err=%b exp=0", e); end
    drv1(1'b0, 5'd19, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (e !== 1'b0 || d !== 16'h5A5A) begin n_err++;
      $display("FAIL edge_rd19 err=%b data=%h exp 0 5a5a", e, d); end
    drv1(1'b0, 5'd20, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (e !== 1'b1 || d !== 16'h0) begin n_err++;
      $display("FAIL edge_rd20 err=%b data=%h exp 1 0000", e, d); end
  endtask

  task automatic test_both;
    int bad, got;
    if0.read = 1'b1; if0.write = 1'b1; if0.addr = 5'd5; if0.data_i = 8'h00; if0.be = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (if0.busy !== 1'b0 || if0.ack !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL both_ignored got=%0d bad cycles exp=0", bad); end
    if0.write = 1'b0;
    got = -1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (if0.ack) begin got = i; break; end
    end
    n_cmp++; if (got !== 4 || if0.data_o !== 8'hA5) begin n_err++;
      $display("FAIL both_then_rd lat=%0d data=%h exp 4 a5", got, if0.data_o); end
    if0.read = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int acks, bad;
    if1.read = 1'b1; if1.addr = 5'd2;
    acks = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (if1.ack) begin
        acks++;
        if (if1.data_o !== 16'hAB34) bad++;
      end
    end
    if1.read = 1'b0;
    n_cmp++; if (acks !== 3) begin n_err++; $display("FAIL b2b_acks got=%0d exp=3", acks); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL b2b_data got=%0d bad exp=0", bad); end
    tick;
  endtask

  task automatic test_reset_mid;
    int lat; logic [15:0] d, dn; logic e, b1, an;
    if1.write = 1'b1; if1.addr = 5'd19; if1.data_i = 16'h0F0F; if1.be = 2'b11;
    tick;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (if1.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", if1.busy); end
    if1.write = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    tick;
    drv1(1'b0, 5'd19, 16'h0000, 2'b00, lat, d, e, b1, an, dn);
    n_cmp++; if (d !== 16'h5A5A) begin n_err++; $display("FAIL rst_mid_mem got=%h exp=5a5a", d); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    if0.read = 1'b0; if0.write = 1'b0; if0.addr = '0; if0.data_i = '0; if0.be = '0;
    if1.read = 1'b0; if1.write = 1'b0; if1.addr = '0; if1.data_i = '0; if1.be = '0;
    test_reset;
    test_basic;
    test_byte_en;
    test_abort;
    test_err;
    test_both;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hs_mem_param.md
Name: hs_mem_param

Overview:
- Parametrised single-port handshake memory with a fixed, configurable response latency.
- Adds byte enables, an out-of-range error response, and a busy indication.
- Requesters hold read/write and the request fields stable until ack. Any change during the wait phase aborts the transaction.
- Sits behind bus-agent test harnesses as a slave memory model / synthesizable scratchpad.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width.
- DEPTH, 32, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W.
- LAT, 3, wait cycles between acceptance and response; range 0..15.
- LAT_MAX, 10, upper latency bound, used only with the optional feature; LAT ≤ LAT_MAX ≤ 15.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- read  input  1  read request, level, held until ack
- write  input  1  write request, level, held until ack
- addr  input  ADDR_W  word address
- data_i  input  DATA_W  write data
- be  input  DATA_W/8  byte enables for writes; bit i covers data_i[8i+7:8i]
- data_o  output  DATA_W  read data, valid only while ack=1
- ack  output  1  single-cycle completion strobe
- err  output  1  qualifies ack; the address was out of range
- busy  output  1  high while a transaction is pending (WAIT or RESP)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; counter, latched op/addr/data/be all cleared.
  - ack=0, err=0, busy=0, data_o=0.
  - Memory array is not reset; its contents are undefined until written.
- States: IDLE, WAIT, RESP. busy = (state != IDLE). ack = (state == RESP).
- IDLE:
  - If exactly one of read/write is high at the clock edge: latch op (0=read, 1=write), addr, data_i, be; load counter = LAT; go to WAIT.
  - read and write both high: ignored, stay IDLE, no error.
- WAIT, checked every edge, highest priority first:
  - Abort if the held request changed: read op with read=0 or addr ≠ latched; write op with write=0 or addr/data_i/be ≠ latched. Go to IDLE; no memory update, no ack.
  - Else if counter ≠ 0: decrement counter.
  - Else go to RESP. On this same edge:
    - Write op, addr < DEPTH: update only enabled bytes of memory[addr].
    - Read op, addr < DEPTH: register memory[addr] into the data_o register.
    - addr ≥ DEPTH: no memory access; set err register; data_o register = 0.
- RESP: lasts exactly one cycle with ack=1 and err as registered, then return to IDLE unconditionally.
  - A request still held in the following IDLE cycle is accepted as a new transaction.
- Outside RESP: data_o=0 and err=0; both are driven from registers, never X.
- Latency:
  - Request accepted at edge N (state=WAIT after N).
  - ack is high for the one cycle between edges N+LAT+1 and N+LAT+2.
  - LAT=0 gives ack one cycle after acceptance.
- Write data is visible to a read accepted in the cycle after the write's ack.
- Reset mid-transaction: the pending transaction is discarded. A write whose RESP edge has not occurred leaves memory unchanged.
- Write with be=0: completes normally with ack, memory unchanged.

Optional Feature:
- Macro: HS_MEM_RAND_LAT_EN.
- Defined: on acceptance, counter loads $urandom_range(LAT, LAT_MAX). This is simulation-only randomised latency for stress testing; all other rules are unchanged.
- Undefined: counter loads LAT; the block is fully deterministic and synthesizable.

Test Plan:
- Reset: hold rst_n=0 with read=1 → ack=0, err=0, busy=0, data_o=0. Release; request accepted on first edge.
- Defaults, LAT=3: write addr=5 data_i=0xA5 be=1 held → busy=1 after the accept edge, ack=1 exactly 4 cycles after acceptance for one cycle. Then read addr=5 → ack with data_o=0xA5, err=0.
- DATA_W=16: write addr=2 data 0x1234 be=2'b11, then write 0xABCD be=2'b10 → read addr=2 returns 0xAB34.
- Abort: write addr=3 data 0x00 (completes); then write addr=3 data 0x11, change data_i to 0x22 one cycle after acceptance → no ack, busy drops next cycle. Read addr=3 returns 0x00.
- DEPTH=20: read addr=25 → ack=1, err=1, data_o=0 in the same cycle. Write addr=25 → ack=1, err=1; a subsequent read of addr 25 also reports err.
- read=1 and write=1 together for 10 cycles → busy=0 and ack=0 throughout. Dropping write then gives a normal read ack after LAT+1 cycles.
